seq_muladd: RTL and testbench

//   Sequential reconstructor: computes X = Q*D + R, the inverse of the CAS-array divider.

---
 rtl/muladd_pkg.sv | 9 +
 rtl/muladd_step.sv | 13 +
 rtl/seq_muladd.sv | 76 +++++++
 tb/tb_seq_muladd.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// muladd_pkg: shared state encodings and sizing helpers for seq_muladd
package muladd_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/muladd_step.sv
// muladd_step: one combinational shift-add iteration of the sequential multiplier
module muladd_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] mcand,
  input  logic         bit_in,
  output logic [W-1:0] acc_nx,
  output logic [W-1:0] mcand_nx
);
  assign acc_nx   = bit_in ? acc + mcand : acc;
  assign mcand_nx = mcand << 1;
endmodule

// File: rtl/seq_muladd.sv
// seq_muladd: sequential X = Q*D + R reconstructor; MULADD_REMCHK_EN adds the rem_err (R >= D) flag
module seq_muladd
  import muladd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   q_in,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [WIDTH-1:0]   r_in,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef MULADD_REMCHK_EN
  output logic [2*WIDTH-1:0] x_out,
  output logic               rem_err
`else
  output logic [2*WIDTH-1:0] x_out
`endif
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam int W2 = 2 * WIDTH;
  logic [1:0]       state;
  logic [W2-1:0]    acc, mcand, acc_nx, mcand_nx, x_q;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             accept, last;
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign x_out     = x_q;
  assign accept    = in_valid && in_ready;
  assign last      = cnt == CNT_W'(WIDTH - 1);
  muladd_step #(.W(W2)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .bit_in   (mplier[0]),
    .acc_nx   (acc_nx),
    .mcand_nx (mcand_nx)
  );
  // x_q snapshots the final accumulator so x_out stays 0 until the first result and never shows partial sums
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      x_q    <= '0;
    end else if (accept) begin
      state  <= ST_RUN;
      acc    <= W2'(r_in);
      mcand  <= W2'(d_in);
      mplier <= q_in;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      acc    <= acc_nx;
      mcand  <= mcand_nx;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        state <= ST_DONE;
        x_q   <= acc_nx;
      end
    end else if (out_valid && out_ready) begin
      state <= ST_IDLE;
    end
  end
`ifdef MULADD_REMCHK_EN
  always_ff @(posedge clk) begin
    if (rst) rem_err <= 1'b0;
    else if (accept) rem_err <= r_in >= d_in;
  end
`endif
endmodule

// File: tb/tb_seq_muladd.sv
// tb_seq_muladd: randomized and directed self-checking bench for seq_muladd against a behavioural model
module tb_seq_muladd;
  localparam int WIDTH = 8;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [7:0]  q_in = 0, d_in = 0, r_in = 0;
  logic [15:0] x_out;
  int checks = 0, failures = 0;
`ifdef MULADD_REMCHK_EN
  logic rem_err;
  logic m_err = 0, m_err_pend = 0;
`endif
  seq_muladd #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .d_in      (d_in),
    .r_in      (r_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MULADD_REMCHK_EN
    .x_out     (x_out),
    .rem_err   (rem_err)
`else
    .x_out     (x_out)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 busy (m_cyc edges elapsed), 2 holding a result
  int   m_phase = 0, m_cyc = 0;
  int   m_exp = 0, m_x = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_cyc <= 0;
      m_x <= 0;
`ifdef MULADD_REMCHK_EN
      m_err <= 0;
`endif
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_phase <= 1;
        m_cyc <= 1;
        m_exp <= int'(q_in) * int'(d_in) + int'(r_in);
`ifdef MULADD_REMCHK_EN
        m_err <= r_in >= d_in;
`endif
      end
    end else if (m_phase == 1) begin
      if (m_cyc == WIDTH) begin
        m_phase <= 2;
        m_x <= m_exp;
      end else m_cyc <= m_cyc + 1;
    end else if (out_ready) m_phase <= 0;
  end

  always @(negedge clk) begin
    chk("cmp_in_ready", in_ready, m_phase == 0);
    chk("cmp_out_valid", out_valid, m_phase == 2);
    chk("cmp_x_out", x_out, m_x);
`ifdef MULADD_REMCHK_EN
    if (m_phase == 2) chk("cmp_rem_err", rem_err, m_err);
`endif
  end

  task automatic accept_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r);
    int n;
    logic rdy;
    q_in = q; d_in = d; r_in = r; in_valid = 1;
    n = 0; rdy = 0;
    while (!rdy && n < 50) begin
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    chk("accept", rdy, 1);
  endtask

  task automatic do_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                       input logic [15:0] ex, input int hold);
    int n;
    accept_op(q, d, r);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, WIDTH);
    chk("result", x_out, ex);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_x", x_out, ex);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
  endtask

  logic [7:0]  bq [3] = '{8'd13, 8'd3, 8'd0};
  logic [7:0]  bd [3] = '{8'd7, 8'd4, 8'd200};
  logic [7:0]  br [3] = '{8'd5, 8'd1, 8'd9};
  logic [15:0] bx [3] = '{16'd96, 16'd13, 16'd9};
  logic [15:0] res [3];

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_x_out", x_out, 0);
    do_op(8'd13, 8'd7, 8'd5, 16'd96, 0);
    do_op(8'd255, 8'd255, 8'd254, 16'd65279, 0);
    do_op(8'd0, 8'd200, 8'd9, 16'd9, 0);
    do_op(8'd77, 8'd0, 8'd3, 16'd3, 0);
    do_op(8'd13, 8'd7, 8'd5, 16'd96, 5);
    // abort an operation mid-run
    rst = 1;
    @(posedge clk); #1 rst = 0;
    accept_op(8'd200, 8'd100, 8'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_x_out", x_out, 0);
    chk("abort_in_ready", in_ready, 1);
    do_op(8'd3, 8'd4, 8'd1, 16'd13, 0);
    begin
      int idx, got;
      logic rdy;
      idx = 0; got = 0;
      q_in = bq[0]; d_in = bd[0]; r_in = br[0];
      in_valid = 1; out_ready = 1;
      for (int c = 0; c < 100 && got < 3; c++) begin
        rdy = in_ready;
        @(posedge clk); #1;
        if (rdy) begin
          idx++;
          if (idx < 3) begin
            q_in = bq[idx]; d_in = bd[idx]; r_in = br[idx];
          end else in_valid = 0;
        end
        if (out_valid) begin
          res[got] = x_out;
          got++;
        end
      end
      in_valid = 0; out_ready = 0;
      chk("b2b_count", got, 3);
      for (int i = 0; i < 3; i++) chk("b2b_result", res[i], bx[i]);
      @(posedge clk); #1;
    end
`ifdef MULADD_REMCHK_EN
    do_op(8'd1, 8'd7, 8'd9, 16'd16, 0);
    chk("remchk_err1", rem_err, 1);
    do_op(8'd1, 8'd7, 8'd6, 16'd13, 0);
    chk("remchk_err0", rem_err, 0);
`endif
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 299) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) == 0;
      q_in = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) ? 8'hff : 8'h00) : 8'($urandom);
      d_in = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) ? 8'hff : 8'h00) : 8'($urandom);
      r_in = $urandom_range(0, 4) == 0 ? ($urandom_range(0, 1) ? 8'hff : 8'h00) : 8'($urandom);
    end
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (20) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
